ray_scan_gen: RTL and testbench

//  Frame scanner directly upstream of the per-pixel view-ray stage. On start it latches view_normal/view_dist.
//  It then walks view_loc over every pixel, row-major. The ray stage answers combinationally on ray_in.

---
 rtl/ray_scan_gen.sv | 168 ++++++++++++++++
 tb/tb_ray_scan_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_scan_gen.sv
// rtl/ray_scan_gen.sv - row-major pixel scanner feeding a combinational view-ray stage, registered valid/ready output
// Optional feature: RAY_SCAN_ABORT_EN adds an abort input that cuts the current frame short.
module ray_scan_gen #(
  parameter int H_RES = 128,
  parameter int V_RES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [27:0] view_normal,
  input  logic [9:0]  view_dist,
  input  logic [27:0] ray_in,
  input  logic        ray_ready,
`ifdef RAY_SCAN_ABORT_EN
  input  logic        abort,
`endif
  output logic [27:0] normal_q,
  output logic [9:0]  dist_q,
  output logic [12:0] view_loc,
  output logic        ray_valid,
  output logic [27:0] ray_data,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        busy,
  output logic        frame_done
);

  // Last column / row index; wraps are compares against these, never overflow.
  localparam logic [6:0] X_LAST = 7'(H_RES - 1);
  localparam logic [5:0] Y_LAST = 6'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [27:0] nrm_q, nrm_d;
  logic [9:0]  dst_q, dst_d;
  logic        valid_q, valid_d;
  logic [27:0] data_q, data_d;
  logic [6:0]  px_q, px_d;
  logic [5:0]  py_q, py_d;
  logic        slot_free;
  logic        abort_hit;

  // Output register may take a new ray when empty or being emptied this cycle.
  assign slot_free = !valid_q || ray_ready;

  // Abort only matters while a frame is actually in flight.
`ifdef RAY_SCAN_ABORT_EN
  assign abort_hit = abort && ((state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and datapath update for the scan FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    nrm_d   = nrm_q;
    dst_d   = dst_q;
    valid_d = valid_q;
    data_d  = data_q;
    px_d    = px_q;
    py_d    = py_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          nrm_d   = view_normal;
          dst_d   = view_dist;
          x_d     = 7'd0;
          y_d     = 6'd0;
        end
      end
      S_LOAD: begin
        // view_loc sits at pixel 0 for a cycle so the ray stage settles.
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (slot_free) begin
          data_d  = ray_in;
          px_d    = x_q;
          py_d    = y_q;
          valid_d = 1'b1;
          if (x_q == X_LAST) begin
            x_d = 7'd0;
            if (y_q == Y_LAST) begin
              y_d     = 6'd0;
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + 6'd1;
            end
          end else begin
            x_d = x_q + 7'd1;
          end
        end
      end
      S_DRAIN: begin
        if (valid_q && ray_ready) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any handshake in the same cycle; the held ray is discarded.
    if (abort_hit) begin
      state_d = S_DONE;
      valid_d = 1'b0;
      x_d     = 7'd0;
      y_d     = 6'd0;
      data_d  = data_q;
      px_d    = px_q;
      py_d    = py_q;
    end
  end

  // State and datapath registers; async reset drops any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= 7'd0;
      y_q     <= 6'd0;
      nrm_q   <= 28'd0;
      dst_q   <= 10'd0;
      valid_q <= 1'b0;
      data_q  <= 28'd0;
      px_q    <= 7'd0;
      py_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      nrm_q   <= nrm_d;
      dst_q   <= dst_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign normal_q   = nrm_q;
  assign dist_q     = dst_q;
  assign view_loc   = {y_q, x_q};
  assign ray_valid  = valid_q;
  assign ray_data   = data_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_ray_scan_gen.sv
// tb/tb_ray_scan_gen.sv - self-checking bench for ray_scan_gen against a pixel-index reference model
module tb_ray_scan_gen;

  localparam int NPIX = 128 * 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] view_normal = '0;
  logic [9:0]  view_dist = '0;
  logic [27:0] ray_in;
  logic        ray_ready = 1'b0;
  logic [27:0] normal_q;
  logic [9:0]  dist_q;
  logic [12:0] view_loc;
  logic        ray_valid;
  logic [27:0] ray_data;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic        busy;
  logic        frame_done;
`ifdef RAY_SCAN_ABORT_EN
  logic        abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int pct;
    bit disturb;
    int reset_at;
    int exp_rays;
    int exp_dones;
  } vec_t;

  vec_t vecs[5];

  ray_scan_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .view_normal(view_normal),
    .view_dist  (view_dist),
    .ray_in     (ray_in),
    .ray_ready  (ray_ready),
`ifdef RAY_SCAN_ABORT_EN
    .abort      (abort),
`endif
    .normal_q   (normal_q),
    .dist_q     (dist_q),
    .view_loc   (view_loc),
    .ray_valid  (ray_valid),
    .ray_data   (ray_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the view-ray stage: a fixed function of pixel location and normal.
  function automatic logic [27:0] ray_f(input logic [12:0] loc, input logic [27:0] nrm);
    return {~loc, 2'b01, loc ^ nrm[12:0]};
  endfunction

  assign ray_in = ray_f(view_loc, normal_q);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_normal_q"}, {4'd0, normal_q}, 32'd0);
    chk({tag, "_dist_q"}, {22'd0, dist_q}, 32'd0);
    chk({tag, "_view_loc"}, {19'd0, view_loc}, 32'd0);
    chk({tag, "_ray_data"}, {4'd0, ray_data}, 32'd0);
    chk({tag, "_pix"}, {19'd0, pix_y, pix_x}, 32'd0);
    chk({tag, "_flags"}, {29'd0, ray_valid, busy, frame_done}, 32'd0);
  endtask

  task automatic run_frame(input int pct, input bit disturb, input int reset_at,
                           input int exp_rays, input int exp_dones);
    logic [27:0] cn;
    logic [9:0]  cd;
    int cyc, k, dones, first_valid, done_cyc, last_x, last_y;
    bit prev_hold, rdy, finished, was_reset;
    logic [27:0] prev_data;
    logic [12:0] prev_pix;
    int exp_loc;
    cn = 28'($urandom);
    cd = 10'($urandom);
    cyc = 0; k = 0; dones = 0; first_valid = -1; done_cyc = -1;
    last_x = -1; last_y = -1; prev_hold = 0; finished = 0; was_reset = 0;
    prev_data = '0; prev_pix = '0;
    @(negedge clk);
    view_normal = cn;
    view_dist = cd;
    start = 1'b1;
    ray_ready = 1'b0;
    while (cyc < 40000 && !finished) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (disturb && cyc == 100) begin
        view_normal = ~cn;
        view_dist = ~cd;
        start = 1'b1;
      end
      if (disturb && cyc == 300) begin
        view_normal = 28'($urandom);
        start = 1'b1;
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, ray_valid}, 32'd1);
        chk("hold_data", {4'd0, ray_data}, {4'd0, prev_data});
        chk("hold_pix", {19'd0, pix_y, pix_x}, {19'd0, prev_pix});
      end
      if (ray_valid && first_valid < 0) first_valid = cyc;
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_single", {31'd0, frame_done}, 32'd0);
        finished = 1;
      end else begin
        if (frame_done) begin
          dones++;
          done_cyc = cyc;
        end
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        exp_loc = k + (ray_valid ? 1 : 0);
        if (!frame_done && exp_loc < NPIX)
          chk("view_loc", {19'd0, view_loc}, 32'(exp_loc));
        if (reset_at >= 0 && k == reset_at) begin
          #2 rst_n = 1'b0;
          #1 check_zero("async_reset");
          chk("no_done_before_reset", 32'(dones), 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          chk("no_done_after_reset", {30'd0, frame_done, busy}, 32'd0);
          was_reset = 1;
          finished = 1;
        end else begin
          rdy = ($urandom_range(0, 99) < pct);
          ray_ready = rdy;
          if (ray_valid && rdy) begin
            chk("ray_x", {25'd0, pix_x}, 32'(k % 128));
            chk("ray_y", {26'd0, pix_y}, 32'(k / 128));
            chk("ray_data", {4'd0, ray_data}, {4'd0, ray_f(13'((k / 128) * 128 + (k % 128)), cn)});
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            k++;
          end
          prev_hold = ray_valid && !rdy;
          prev_data = ray_data;
          prev_pix = {pix_y, pix_x};
        end
      end
    end
    ray_ready = 1'b0;
    start = 1'b0;
    chk("frame_terminated", {31'd0, finished}, 32'd1);
    chk("ray_count", 32'(k), 32'(exp_rays));
    chk("done_count", 32'(dones), 32'(exp_dones));
    if (!was_reset) begin
      chk("last_x", 32'(last_x), 32'd127);
      chk("last_y", 32'(last_y), 32'd63);
      chk("normal_held", {4'd0, normal_q}, {4'd0, cn});
      chk("dist_held", {22'd0, dist_q}, {22'd0, cd});
      if (pct == 100) begin
        chk("first_valid_cycle", 32'(first_valid), 32'd3);
        chk("done_cycle", 32'(done_cyc), 32'(NPIX + 3));
      end
    end
  endtask

`ifdef RAY_SCAN_ABORT_EN
  task automatic run_abort();
    int k;
    int guard;
    k = 0;
    guard = 0;
    @(negedge clk);
    view_normal = 28'($urandom);
    view_dist = 10'($urandom);
    start = 1'b1;
    ray_ready = 1'b1;
    while (k < 500 && guard < 2000) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (ray_valid) k++;
    end
    chk("abort_reached", 32'(k), 32'd500);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", {31'd0, ray_valid}, 32'd0);
    chk("abort_done", {31'd0, frame_done}, 32'd1);
    chk("abort_loc", {19'd0, view_loc}, 32'd0);
    @(negedge clk);
    chk("abort_idle", {30'd0, busy, frame_done}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_idle", {30'd0, busy, frame_done}, 32'd0);
    ray_ready = 1'b0;
  endtask
`endif

  initial begin
    vecs[0] = '{pct: 100, disturb: 1'b0, reset_at: -1,   exp_rays: NPIX, exp_dones: 1};
    vecs[1] = '{pct: 50,  disturb: 1'b1, reset_at: -1,   exp_rays: NPIX, exp_dones: 1};
    vecs[2] = '{pct: 100, disturb: 1'b0, reset_at: 1000, exp_rays: 1000, exp_dones: 0};
    vecs[3] = '{pct: 100, disturb: 1'b1, reset_at: -1,   exp_rays: NPIX, exp_dones: 1};
    vecs[4] = '{pct: 75,  disturb: 1'b0, reset_at: -1,   exp_rays: NPIX, exp_dones: 1};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].pct, vecs[i].disturb, vecs[i].reset_at, vecs[i].exp_rays, vecs[i].exp_dones);

`ifdef RAY_SCAN_ABORT_EN
    run_abort();
    run_frame(100, 1'b0, -1, NPIX, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
